// File: rtl/exc_ctrl_if.sv
// Exception controller bus: groups the pipeline-facing signals of exc_ctrl.
//   master : the pipeline side (drives M-stage info, interrupt lines, mtc0/mfc0/eret)
//   slave  : exc_ctrl (drives the flush request, EPC, mfc0 data, EXL and the FSM state)
// Handshake semantics: there is no valid/ready pair. IntReg is a combinational,
// single-cycle flush strobe; the pipeline registers clear on the same posedge
// that sees IntReg=1, and the controller commits its exception entry on that
// same edge, so no acknowledgement is needed.
interface exc_ctrl_if;
  logic [31:0] PC_M;
  logic        BD_M;
  logic        ExcValid_M;
  logic [4:0]  ExcCode_M;
  logic [5:0]  HWInt;
  logic        We;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        Eret_M;
  logic        IntReg;
  logic [31:0] EPC_out;
  logic [31:0] DOut;
  logic        Exl_out;
  logic        state_dbg;   // 0 = NORMAL, 1 = HANDLER

  modport master (
    output PC_M, BD_M, ExcValid_M, ExcCode_M, HWInt, We, A1, A2, DIn, Eret_M,
    input  IntReg, EPC_out, DOut, Exl_out, state_dbg
  );

  modport slave (
    input  PC_M, BD_M, ExcValid_M, ExcCode_M, HWInt, We, A1, A2, DIn, Eret_M,
    output IntReg, EPC_out, DOut, Exl_out, state_dbg
  );
endinterface

// File: rtl/exc_ctrl.sv
// exc_ctrl: CP0-style exception/interrupt controller beside the M stage of a
// 5-stage MIPS pipeline. Holds SR(12), Cause(13), EPC(14), PRId(15).
// Ports:
//   clk    : system clock, all state on posedge
//   reset  : synchronous, active-high
//   bus    : exc_ctrl_if.slave (M-stage PC/BD/exception info, HWInt, mtc0/mfc0,
//            eret in; IntReg flush, EPC_out, DOut, Exl_out, state_dbg out)
module exc_ctrl #(
  parameter logic [31:0] PRID     = 32'h0000_2019,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic       clk,
  input  logic       reset,
  exc_ctrl_if.slave  bus
);

  typedef enum logic {NORMAL = 1'b0, HANDLER = 1'b1} state_t;

  state_t      state_q;
  logic [5:0]  im_q;
  logic        exl_q;
  logic        ie_q;
  logic        bd_q;
  logic [5:0]  ip_q;
  logic [4:0]  exccode_q;
  logic [31:0] epc_q;
  logic [31:0] last_pc_q;

  logic        irq;
  logic        exc;
  logic        int_req;
  logic [31:0] epc_base_d;
  logic [31:0] epc_d;
  logic [4:0]  exccode_d;

  // EXL blocks both sources, so nothing nests until eret (or an mtc0) clears it.
  assign irq     = ie_q & ~exl_q & (|(bus.HWInt & im_q));
  assign exc     = bus.ExcValid_M & ~exl_q;
  assign int_req = irq | exc;

  // A bubble in M has PC 0; fall back to the last real PC seen so the
  // handler returns to an instruction that has not yet committed.
  assign epc_base_d = (bus.PC_M != 32'd0) ? bus.PC_M : last_pc_q;

  always_comb begin
    epc_d      = bus.BD_M ? (epc_base_d - 32'd4) : epc_base_d;
    epc_d[1:0] = 2'b00;
  end

  // Interrupts take priority and report code 0.
  assign exccode_d = irq ? 5'd0 : bus.ExcCode_M;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= NORMAL;
      im_q      <= 6'd0;
      exl_q     <= 1'b0;
      ie_q      <= 1'b0;
      bd_q      <= 1'b0;
      ip_q      <= 6'd0;
      exccode_q <= 5'd0;
      epc_q     <= 32'd0;
      last_pc_q <= RESET_PC;
    end else begin
      ip_q <= bus.HWInt;
      if (int_req) begin
        // Entry: the flushed M instruction does not commit, so its mtc0 is dropped.
        exl_q     <= 1'b1;
        state_q   <= HANDLER;
        bd_q      <= bus.BD_M;
        exccode_q <= exccode_d;
        epc_q     <= epc_d;
      end else begin
        if (bus.PC_M != 32'd0) begin
          last_pc_q <= bus.PC_M;
        end
        if (bus.We && bus.A2 == 5'd12) begin
          im_q    <= bus.DIn[15:10];
          exl_q   <= bus.DIn[1];
          ie_q    <= bus.DIn[0];
          // Keep the FSM in step with EXL so a software clear cannot strand it.
          state_q <= bus.DIn[1] ? HANDLER : NORMAL;
        end
        if (bus.We && bus.A2 == 5'd14) begin
          epc_q <= {bus.DIn[31:2], 2'b00};
        end
        // Placed after the SR write so eret wins over a same-cycle EXL write.
        if (bus.Eret_M && exl_q) begin
          exl_q   <= 1'b0;
          state_q <= NORMAL;
        end
      end
    end
  end

  always_comb begin
    bus.DOut = 32'd0;
    case (bus.A1)
      5'd12:   bus.DOut = {16'd0, im_q, 8'd0, exl_q, ie_q};
      5'd13:   bus.DOut = {bd_q, 15'd0, ip_q, 3'd0, exccode_q, 2'b00};
      5'd14:   bus.DOut = epc_q;
      5'd15:   bus.DOut = PRID;
      default: bus.DOut = 32'd0;
    endcase
  end

  assign bus.IntReg    = int_req;
  assign bus.EPC_out   = epc_q;
  assign bus.Exl_out   = exl_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: expectations are queued as stimulus is driven
// and popped when the matching DUT output is sampled.
module tb_exc_ctrl;
  logic clk;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  logic [31:0] exp_q[$];

  exc_ctrl_if bus ();

  exc_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected Cause value from its fields
  function automatic logic [31:0] cause_of(input logic bd, input logic [5:0] ip,
                                           input logic [4:0] code);
    return {bd, 15'd0, ip, 3'd0, code, 2'b00};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.PC_M       = 32'd0;
    bus.BD_M       = 1'b0;
    bus.ExcValid_M = 1'b0;
    bus.ExcCode_M  = 5'd0;
    bus.We         = 1'b0;
    bus.A1         = 5'd0;
    bus.A2         = 5'd0;
    bus.DIn        = 32'd0;
    bus.Eret_M     = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    bus.We   = 1'b1;
    bus.A2   = a;
    bus.DIn  = d;
    bus.PC_M = pc;
    tick();
    bus.We   = 1'b0;
    bus.PC_M = 32'd0;
  endtask

  // scoreboard
  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL %s: observed %h, nothing queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        fails++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic check_reg(input string tag, input logic [4:0] a, input logic [31:0] v);
    bus.A1 = a;
    #1;
    expect_val(v);
    check(tag, bus.DOut);
  endtask

  task automatic check_sig(input string tag, input logic [31:0] obs, input logic [31:0] v);
    expect_val(v);
    check(tag, obs);
  endtask

  initial begin
    idle();
    bus.HWInt = 6'd0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // reset state
    check_sig("rst_intreg", {31'd0, bus.IntReg}, 32'd0);
    check_sig("rst_epc", bus.EPC_out, 32'd0);
    check_sig("rst_exl", {31'd0, bus.Exl_out}, 32'd0);
    check_sig("rst_state", {31'd0, bus.state_dbg}, 32'd0);
    check_reg("rst_sr", 5'd12, 32'd0);
    check_reg("rst_cause", 5'd13, 32'd0);
    check_reg("prid", 5'd15, 32'h0000_2019);
    check_reg("unmapped_rd", 5'd7, 32'd0);

    // enable all lines, IE=1
    mtc0(5'd12, 32'h0000_FC01, 32'd0);
    check_reg("sr_write", 5'd12, 32'h0000_FC01);
    mtc0(5'd13, 32'hFFFF_FFFF, 32'd0);
    check_reg("cause_ro", 5'd13, 32'd0);

    // interrupt on HWInt[2]
    bus.HWInt = 6'b000100;
    bus.PC_M  = 32'h0000_3010;
    #1;
    check_sig("irq_intreg", {31'd0, bus.IntReg}, 32'd1);
    tick();
    check_sig("irq_epc", bus.EPC_out, 32'h0000_3010);
    check_sig("irq_exl", {31'd0, bus.Exl_out}, 32'd1);
    check_sig("irq_state", {31'd0, bus.state_dbg}, 32'd1);
    check_reg("irq_cause", 5'd13, cause_of(1'b0, 6'b000100, 5'd0));

    // nested request blocked while EXL=1
    bus.ExcValid_M = 1'b1;
    bus.ExcCode_M  = 5'd12;
    bus.PC_M       = 32'h0000_3014;
    #1;
    check_sig("nest_intreg", {31'd0, bus.IntReg}, 32'd0);
    tick();
    check_sig("nest_epc", bus.EPC_out, 32'h0000_3010);
    check_reg("nest_cause", 5'd13, cause_of(1'b0, 6'b000100, 5'd0));

    // eret, then the held interrupt is taken the following cycle
    bus.ExcValid_M = 1'b0;
    bus.ExcCode_M  = 5'd0;
    bus.Eret_M     = 1'b1;
    bus.PC_M       = 32'h0000_3018;
    #1;
    check_sig("eret_intreg", {31'd0, bus.IntReg}, 32'd0);
    tick();
    bus.Eret_M = 1'b0;
    check_sig("eret_exl", {31'd0, bus.Exl_out}, 32'd0);
    bus.PC_M = 32'h0000_3030;
    #1;
    check_sig("post_eret_intreg", {31'd0, bus.IntReg}, 32'd1);
    tick();
    check_sig("post_eret_epc", bus.EPC_out, 32'h0000_3030);
    bus.HWInt = 6'd0;

    // exception in a delay slot with IE=0 (also clears EXL via SR)
    mtc0(5'd12, 32'h0000_FC00, 32'd0);
    check_sig("sr_clr_exl", {31'd0, bus.Exl_out}, 32'd0);
    bus.ExcValid_M = 1'b1;
    bus.ExcCode_M  = 5'd12;
    bus.PC_M       = 32'h0000_3024;
    bus.BD_M       = 1'b1;
    #1;
    check_sig("exc_intreg", {31'd0, bus.IntReg}, 32'd1);
    tick();
    idle();
    check_sig("exc_epc", bus.EPC_out, 32'h0000_3020);
    check_reg("exc_cause", 5'd13, 32'h8000_0030);

    // interrupt while M holds a bubble: EPC comes from last valid PC
    mtc0(5'd12, 32'h0000_FC01, 32'h0000_3040);
    bus.HWInt = 6'b000001;
    bus.PC_M  = 32'd0;
    #1;
    check_sig("bubble_intreg", {31'd0, bus.IntReg}, 32'd1);
    tick();
    check_sig("bubble_epc", bus.EPC_out, 32'h0000_3040);
    check_reg("bubble_cause", 5'd13, cause_of(1'b0, 6'b000001, 5'd0));
    bus.HWInt = 6'd0;

    // mtc0 EPC suppressed by a same-cycle interrupt
    mtc0(5'd12, 32'h0000_FC01, 32'h0000_3050);
    bus.HWInt = 6'b000010;
    bus.PC_M  = 32'h0000_3060;
    bus.We    = 1'b1;
    bus.A2    = 5'd14;
    bus.DIn   = 32'h1234_5677;
    #1;
    check_sig("mtc0_irq_intreg", {31'd0, bus.IntReg}, 32'd1);
    tick();
    idle();
    bus.HWInt = 6'd0;
    check_sig("mtc0_irq_epc", bus.EPC_out, 32'h0000_3060);
    bus.Eret_M = 1'b1;
    tick();
    bus.Eret_M = 1'b0;
    bus.We  = 1'b1;
    bus.A2  = 5'd14;
    bus.DIn = 32'h1234_5677;
    #1;
    check_sig("epc_before_edge", bus.EPC_out, 32'h0000_3060);
    tick();
    idle();
    check_sig("epc_write", bus.EPC_out, 32'h1234_5674);

    // pending interrupt held off by IE=0, taken right after IE is set
    mtc0(5'd12, 32'h0000_FC00, 32'd0);
    bus.HWInt = 6'b001000;
    #1;
    check_sig("masked_intreg", {31'd0, bus.IntReg}, 32'd0);
    tick();
    check_sig("masked_intreg2", {31'd0, bus.IntReg}, 32'd0);
    bus.We   = 1'b1;
    bus.A2   = 5'd12;
    bus.DIn  = 32'h0000_FC01;
    bus.PC_M = 32'h0000_3070;
    #1;
    check_sig("ie_set_cycle", {31'd0, bus.IntReg}, 32'd0);
    tick();
    idle();
    bus.PC_M = 32'h0000_3074;
    #1;
    check_sig("ie_next_intreg", {31'd0, bus.IntReg}, 32'd1);
    tick();
    idle();
    bus.HWInt = 6'd0;
    check_sig("ie_next_epc", bus.EPC_out, 32'h0000_3074);

    // eret beats a same-cycle SR write that sets EXL
    bus.Eret_M = 1'b1;
    bus.We     = 1'b1;
    bus.A2     = 5'd12;
    bus.DIn    = 32'h0000_FC03;
    tick();
    idle();
    check_sig("eret_wins_exl", {31'd0, bus.Exl_out}, 32'd0);
    check_reg("eret_wins_sr", 5'd12, 32'h0000_FC01);

    // reset while in HANDLER with HWInt held
    bus.HWInt = 6'b000001;
    bus.PC_M  = 32'h0000_3080;
    tick();
    bus.PC_M = 32'd0;
    check_sig("pre_rst_state", {31'd0, bus.state_dbg}, 32'd1);
    reset = 1'b1;
    tick();
    check_sig("hrst_intreg", {31'd0, bus.IntReg}, 32'd0);
    check_sig("hrst_epc", bus.EPC_out, 32'd0);
    check_sig("hrst_state", {31'd0, bus.state_dbg}, 32'd0);
    check_reg("hrst_sr", 5'd12, 32'd0);
    check_reg("hrst_prid", 5'd15, 32'h0000_2019);
    reset = 1'b0;
    tick();
    check_sig("after_rst_intreg", {31'd0, bus.IntReg}, 32'd0);

    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $error("FAIL leftover_expect: observed %0d queued, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception/interrupt controller for the 5-stage MIPS pipeline. It sits beside the memory stage.
- It evaluates hardware interrupts and stage-carried exception codes at the M stage and raises the one-cycle flush (IntReg) that clears all pipeline registers.
- It holds the SR, Cause, EPC and PRId registers, serves mfc0/mtc0, and supplies EPC for eret.
- A two-state machine (NORMAL/HANDLER) blocks nested entry until eret.

Parameters:
- PRID, 32'h0000_2019, value returned when reading register 15.
- RESET_PC, 32'h0000_3000, initial value of the last-valid-PC tracker.

Ports:
- clk  input  1  system clock, all state on posedge.
- reset  input  1  synchronous, active-high reset.
- PC_M  input  32  PC of the instruction in M; 0 means bubble.
- BD_M  input  1  M instruction is in a branch delay slot.
- ExcValid_M  input  1  M instruction carries an exception.
- ExcCode_M  input  5  exception code carried to M.
- HWInt  input  6  external interrupt lines, level-sensitive.
- We  input  1  mtc0 in M.
- A1  input  5  mfc0 read register number.
- A2  input  5  mtc0 write register number.
- DIn  input  32  mtc0 write data.
- Eret_M  input  1  eret in M.
- IntReg  output  1  flush request to pipeline registers, combinational.
- EPC_out  output  32  current EPC, used as the eret target.
- DOut  output  32  mfc0 read data, combinational on A1.
- Exl_out  output  1  SR.EXL, for debug/bench.

Behaviour:
- Register fields:
  - SR (12): IM=[15:10], EXL=[1], IE=[0]; other bits read 0.
  - Cause (13): BD=[31], IP=[15:10], ExcCode=[6:2]; other bits read 0.
  - EPC (14): full 32 bits.
  - PRId (15): reads PRID.
  - Any other A1 reads 0.
- Reset (synchronous):
  - SR=0, Cause=0, EPC=0, last_pc=RESET_PC, state=NORMAL.
  - Outputs follow: IntReg=0, EPC_out=0, Exl_out=0.
- Interrupt request: irq = IE & !EXL & |(HWInt & IM).
- Exception request: exc = ExcValid_M & !EXL.
- IntReg = irq | exc, combinational, same cycle. Pipeline registers act on it at the same edge, giving zero-cycle latency.
- Priority: irq wins over exc. On irq, ExcCode=0; otherwise ExcCode=ExcCode_M.
- On a posedge with IntReg=1:
  - EXL<=1 and state<=HANDLER.
  - Cause.BD<=BD_M; ExcCode written as above.
  - EPC target base = (PC_M!=0) ? PC_M : last_pc.
  - EPC <= BD_M ? base-4 : base, then forced to [1:0]=0.
  - An mtc0 in the same cycle is suppressed, since the flushed instruction does not commit.
- last_pc: updates to PC_M on every posedge where PC_M!=0 and IntReg=0. This covers interrupts arriving while M holds a bubble after a stall or flush.
- Cause.IP: <=HWInt every cycle, independent of state or masks.
- mtc0 (We=1, IntReg=0):
  - A2=12: SR<=DIn masked to IM/EXL/IE.
  - A2=14: EPC<={DIn[31:2],2'b00}.
  - Writes to 13, 15 and other numbers are ignored.
- eret (Eret_M=1 with EXL=1): EXL<=0, state<=NORMAL at the edge. In that cycle IntReg=0 because EXL is still 1. eret with EXL=0 is a no-op.
- mtc0 to SR with an EXL bit in the same cycle as eret: eret wins (EXL<=0).
- HANDLER state: no irq or exc is taken. Exceptions carried in are dropped and Cause is unchanged.
- Interrupt pending while IE=0 or IM masks it: it stays pending. It is taken the first cycle the masks allow, including the cycle right after an mtc0 sets IE.
- EPC_out reflects the registered EPC, so writes are visible the next cycle.

Test Plan:
- Reset, then SR=0x0000FC01 via mtc0. Assert HWInt[2] with PC_M=0x3010, BD_M=0 → IntReg=1 that cycle. After the edge: EPC=0x3010, Cause.ExcCode=0, Cause.IP[12]=1, EXL=1.
- ExcValid_M=1, ExcCode_M=12 (Ov), PC_M=0x3024, BD_M=1, IE=0 → IntReg=1. After the edge: EPC=0x3020, Cause=0x80000030.
- With EXL=1, assert HWInt and ExcValid_M → IntReg=0 and no register change. Then Eret_M → EXL=0 next cycle. The interrupt is then taken the following cycle.
- Flush a bubble: PC_M=0 while last_pc=0x3040, then assert HWInt[0] with IM[10]=1, IE=1 → EPC=0x3040.
- mtc0 A2=14 with DIn=0x12345677 in the same cycle as an interrupt → EPC=interrupt PC and the write is discarded. Repeat without the interrupt → EPC_out=0x12345674 next cycle.
- Reset asserted while in HANDLER with HWInt held → SR=0, EPC=0, IntReg=0. DOut(A1=15)=0x00002019.
